// File: rtl/exc_pkg.sv
// Shared types and constants for the exception unit: FSM state encoding,
// cause codes and the default handler entry address.
package exc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHandler = 2'd1,
    StFault   = 2'd2
  } exc_state_e;

  localparam logic [3:0] CAUSE_NONE     = 4'h0;
  localparam logic [3:0] CAUSE_BADINSTR = 4'h1;
  localparam logic [3:0] CAUSE_EXTIRQ   = 4'h2;
  localparam logic [3:0] CAUSE_TIMER    = 4'h3;

  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'hD8;

endpackage

// File: rtl/exc_timer.sv
// Free-running period counter; emits a one-cycle tick when it wraps from
// TIMER_PERIOD-1 back to 0.
module exc_timer #(
  parameter int unsigned TIMER_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(TIMER_PERIOD - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt sequencer: redirects fetch to the handler on illegal
// instructions and interrupts, returns on ERET. Timer source under EXC_TIMER_EN.
module exception_unit
  import exc_pkg::*;
#(
  parameter int unsigned   N            = 64,
  parameter logic [N-1:0]  EXC_VECTOR   = EXC_VECTOR_DEFAULT[N-1:0],
  parameter int unsigned   TIMER_PERIOD = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] imem_addr_F,
  input  logic [N-1:0] NextPC_F,
  input  logic         BadInstr_D,
  input  logic         ExtIRQ,
  input  logic         ERet_D,
  input  logic         ExcAck,
  output logic         EProc_F,
  output logic [N-1:0] EVAddr_F,
  output logic [N-1:0] ERR,
  output logic [3:0]   ESync,
  output logic         InHandler,
  output logic         DoubleFault
);

  exc_state_e   state_q, state_d;
  logic [N-1:0] err_q, err_d;
  logic [3:0]   esync_q, esync_d;
  logic         df_q, df_d;
  logic         ext_pend_q, ext_pend_d;
  logic         tmr_pend_q, tmr_pend_d;
  logic         tick;

`ifdef EXC_TIMER_EN
  exc_timer #(
    .TIMER_PERIOD(TIMER_PERIOD)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );
`else
  localparam int unsigned unused_timer_period = TIMER_PERIOD;
  assign tick = 1'b0;
`endif

  // ERET outside the handler is illegal; an external request this cycle is
  // taken without waiting for the latch.
  logic bad_idle, ext_take, irq_take;
  assign bad_idle = BadInstr_D | ERet_D;
  assign ext_take = ExtIRQ | ext_pend_q;
  assign irq_take = ext_take | tmr_pend_q;

  // Acknowledge wins over a same-cycle set.
  assign ext_pend_d = ExcAck ? 1'b0 : (ext_pend_q | ExtIRQ);
  assign tmr_pend_d = ExcAck ? 1'b0 : (tmr_pend_q | tick);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      err_q      <= '0;
      esync_q    <= CAUSE_NONE;
      df_q       <= 1'b0;
      ext_pend_q <= 1'b0;
      tmr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      esync_q    <= esync_d;
      df_q       <= df_d;
      ext_pend_q <= ext_pend_d;
      tmr_pend_q <= tmr_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    esync_d = esync_q;
    df_d    = df_q;
    unique case (state_q)
      StIdle: begin
        if (bad_idle) begin
          err_d   = imem_addr_F;
          esync_d = CAUSE_BADINSTR;
          state_d = StHandler;
        end else if (irq_take) begin
          err_d   = NextPC_F;
          esync_d = ext_take ? CAUSE_EXTIRQ : CAUSE_TIMER;
          state_d = StHandler;
        end
      end
      StHandler: begin
        if (BadInstr_D) begin
          state_d = StFault;
          df_d    = 1'b1;
        end else if (ERet_D) begin
          state_d = StIdle;
        end
      end
      StFault: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    EProc_F  = 1'b0;
    EVAddr_F = EXC_VECTOR;
    if (!reset) begin
      unique case (state_q)
        StIdle: EProc_F = bad_idle | irq_take;
        StHandler: begin
          if (!BadInstr_D && ERet_D) begin
            EProc_F  = 1'b1;
            EVAddr_F = err_q;
          end
        end
        StFault: begin
          EProc_F  = 1'b1;
          EVAddr_F = imem_addr_F;
        end
        default: ;
      endcase
    end
  end

  assign ERR         = err_q;
  assign ESync       = esync_q;
  assign InHandler   = (state_q == StHandler);
  assign DoubleFault = df_q;

endmodule

// File: tb/tb_exception_unit.sv
// Table-driven bench for exception_unit; the timer instance check is built
// only when EXC_TIMER_EN is defined.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        reset, bad, irq, eret, ack;
  logic [63:0] pc, npc;
  logic        eproc, inh, df;
  logic [63:0] vaddr, err;
  logic [3:0]  esync;

  int total = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  exception_unit #(
    .N(64), .EXC_VECTOR(64'hD8), .TIMER_PERIOD(1000)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr_F(pc), .NextPC_F(npc), .BadInstr_D(bad),
    .ExtIRQ(irq), .ERet_D(eret), .ExcAck(ack), .EProc_F(eproc), .EVAddr_F(vaddr),
    .ERR(err), .ESync(esync), .InHandler(inh), .DoubleFault(df)
  );

`ifdef EXC_TIMER_EN
  logic        t_rst;
  logic        t_zero = 1'b0;
  logic [63:0] t_zw = '0;
  logic        t_eproc, t_inh, t_df;
  logic [63:0] t_vaddr, t_err;
  logic [3:0]  t_esync;

  exception_unit #(
    .N(64), .EXC_VECTOR(64'hD8), .TIMER_PERIOD(8)
  ) dut_tmr (
    .clk(clk), .reset(t_rst), .imem_addr_F(t_zw), .NextPC_F(t_zw), .BadInstr_D(t_zero),
    .ExtIRQ(t_zero), .ERet_D(t_zero), .ExcAck(t_zero), .EProc_F(t_eproc),
    .EVAddr_F(t_vaddr), .ERR(t_err), .ESync(t_esync), .InHandler(t_inh),
    .DoubleFault(t_df)
  );
`endif

  typedef struct {
    logic        rst, bad, irq, eret, ack;
    logic [63:0] pc, npc;
    logic        x_eproc;
    logic [63:0] x_vaddr;
    logic [63:0] x_err;
    logic [3:0]  x_sync;
    logic        x_inh, x_df;
  } vec_t;

  vec_t tbl[18];
  vec_t exp_q[$];
  vec_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic b, input logic i, input logic er,
                              input logic a, input logic [63:0] p, input logic [63:0] np,
                              input logic xe, input logic [63:0] xv, input logic [63:0] xr,
                              input logic [3:0] xs, input logic xi, input logic xd);
    vec_t v;
    v.rst = r; v.bad = b; v.irq = i; v.eret = er; v.ack = a; v.pc = p; v.npc = np;
    v.x_eproc = xe; v.x_vaddr = xv; v.x_err = xr; v.x_sync = xs; v.x_inh = xi; v.x_df = xd;
    return v;
  endfunction

  initial begin
    //             rst b  i  er a  pc      npc     eproc vaddr   err     sync inh df
    tbl[0]  = mk(1, 1, 0, 0, 0, 64'h40,  64'h44,  0, 64'hD8,  64'h0,   0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 64'h40,  64'h44,  1, 64'hD8,  64'h40,  1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 64'hD8,  64'hDC,  1, 64'h40,  64'h40,  1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 64'h100, 64'h104, 1, 64'hD8,  64'h104, 2, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 64'hDC,  64'hE0,  1, 64'h104, 64'h104, 2, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 64'h104, 64'h108, 0, 64'hD8,  64'h104, 2, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 64'h200, 64'h204, 1, 64'hD8,  64'h200, 1, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 64'hD8,  64'hDC,  0, 64'hD8,  64'h200, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 64'hDC,  64'hE0,  1, 64'h200, 64'h200, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 64'h200, 64'h300, 1, 64'hD8,  64'h300, 2, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 64'hD8,  64'hDC,  0, 64'hD8,  64'h300, 2, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 64'hE0,  64'hE4,  0, 64'hD8,  64'h300, 2, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 64'hE4,  64'hE8,  1, 64'hE4,  64'h300, 2, 0, 1);
    tbl[13] = mk(0, 0, 1, 1, 0, 64'hE8,  64'hEC,  1, 64'hE8,  64'h300, 2, 0, 1);
    tbl[14] = mk(1, 0, 0, 0, 0, 64'hE8,  64'hEC,  0, 64'hD8,  64'h0,   0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 64'h80,  64'h84,  1, 64'hD8,  64'h80,  1, 1, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 64'hD8,  64'hDC,  0, 64'hD8,  64'h0,   0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 64'h84,  64'h88,  0, 64'hD8,  64'h0,   0, 0, 0);

    reset = 1'b1; bad = 1'b0; irq = 1'b0; eret = 1'b0; ack = 1'b0; pc = '0; npc = '0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; bad = tbl[i].bad; irq = tbl[i].irq; eret = tbl[i].eret;
      ack = tbl[i].ack; pc = tbl[i].pc; npc = tbl[i].npc;
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d eproc", i), {63'b0, eproc}, {63'b0, e.x_eproc});
      chk($sformatf("row%0d evaddr", i), vaddr, e.x_vaddr);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d err", i), err, e.x_err);
      chk($sformatf("row%0d esync", i), {60'b0, esync}, {60'b0, e.x_sync});
      chk($sformatf("row%0d inhandler", i), {63'b0, inh}, {63'b0, e.x_inh});
      chk($sformatf("row%0d doublefault", i), {63'b0, df}, {63'b0, e.x_df});
    end

    // Quiet run: nothing should redirect within 100 cycles of reset.
    begin
      int hits = 0;
      @(negedge clk);
      bad = 1'b0; irq = 1'b0; eret = 1'b0; ack = 1'b0; reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
        #1;
        if (eproc) hits++;
        @(negedge clk);
      end
      chk("quiet_no_redirect", 64'(hits), 64'd0);
      chk("quiet_esync", {60'b0, esync}, 64'd0);
    end

`ifdef EXC_TIMER_EN
    begin
      int first = -1;
      t_rst = 1'b1;
      @(posedge clk);
      #1 t_rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (t_eproc && first < 0) first = k;
        @(posedge clk);
        #1;
      end
      chk("timer_first_redirect", 64'(first), 64'd8);
      chk("timer_esync", {60'b0, t_esync}, 64'd3);
      chk("timer_inhandler", {63'b0, t_inh}, 64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

`ifdef EXC_TIMER_EN
  initial t_rst = 1'b1;
`endif

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter N, default 64: address/data width.
REQ-002 Parameter EXC_VECTOR, default 64'hD8: handler entry address.
REQ-003 Parameter TIMER_PERIOD, default 1000: timer interrupt period in cycles; only used with EXC_TIMER_EN.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high.
REQ-006 imem_addr_F  input  N: PC of the instruction executing this cycle.
REQ-007 NextPC_F  input  N: non-exception next PC from fetch (PC+4 or branch target).
REQ-008 BadInstr_D  input  1: decoder flags the current instruction as an illegal opcode.
REQ-009 ExtIRQ  input  1: level-sensitive external interrupt request.
REQ-010 ERet_D  input  1: current instruction is ERET.
REQ-011 ExcAck  input  1: handler acknowledge; clears the pending interrupt latch.
REQ-012 EProc_F  output  1: redirect fetch to EVAddr_F this cycle.
REQ-013 EVAddr_F  output  N: redirect target.
REQ-014 ERR  output  N: saved exception return address.
REQ-015 ESync  output  4: cause code of the last taken exception.
REQ-016 InHandler  output  1: handler state active; high when state is HANDLER.
REQ-017 DoubleFault  output  1: sticky fault indicator.

Function
REQ-018 States: IDLE, HANDLER, FAULT; the encoding is defined in the package.
REQ-019 irq_pend latch: set on any cycle with ExtIRQ=1 or timer tick; cleared by ExcAck=1; clear wins over a simultaneous set.
REQ-020 IDLE with BadInstr_D=1: EProc_F=1 and EVAddr_F=EXC_VECTOR in the same cycle (combinational); next edge: ERR<=imem_addr_F, ESync<=4'h1, state<=HANDLER.
REQ-021 IDLE with BadInstr_D=0 and irq_pend=1 (or ExtIRQ=1 this cycle): EProc_F=1, EVAddr_F=EXC_VECTOR; next edge: ERR<=NextPC_F, ESync<=4'h2 (external) or 4'h3 (timer only), state<=HANDLER.
REQ-022 Priority: BadInstr_D > external IRQ > timer; ERET_D in IDLE is treated as BadInstr_D.
REQ-023 HANDLER: interrupts are masked; irq_pend still accumulates and no redirect is taken for it.
REQ-024 HANDLER with ERet_D=1: EProc_F=1, EVAddr_F=ERR; next edge: state<=IDLE.
REQ-025 A still-pending IRQ is taken on the first IDLE cycle after ERET, with zero bubble cycles.
REQ-026 HANDLER with BadInstr_D=1: EProc_F=0; next edge: state<=FAULT, DoubleFault<=1; ERR and ESync are unchanged.
REQ-027 FAULT: EProc_F=1, EVAddr_F=imem_addr_F every cycle (PC held); only reset exits FAULT.
REQ-028 EProc_F=0 in every case not listed above; EVAddr_F=EXC_VECTOR whenever EProc_F=0.
REQ-029 ERR and ESync change only on exception entry.

Reset
REQ-030 On reset=1 at an edge: state<=IDLE, ERR<=0, ESync<=0, irq_pend<=0, DoubleFault<=0, timer count<=0; this applies in any state, including mid-handler.
REQ-031 EProc_F=0 during any cycle with reset=1.

Configuration
REQ-032 EXC_TIMER_EN defined: an internal counter increments every cycle, wraps from TIMER_PERIOD-1 to 0, and emits a one-cycle tick on the wrap.
REQ-033 EXC_TIMER_EN undefined: no counter exists, the tick is constant 0, and cause 4'h3 is never produced.

Structure
REQ-034 Package exc_pkg holds the state enum, the cause codes (CAUSE_NONE=0, CAUSE_BADINSTR=1, CAUSE_EXTIRQ=2, CAUSE_TIMER=3) and the EXC_VECTOR default.
REQ-035 The timer is sub-module exc_timer (inputs clk, reset; output tick), instantiated only under EXC_TIMER_EN.
REQ-036 The top level instantiates fetch-side wiring only through the EProc_F and EVAddr_F outputs; no memory is included.

Verification
REQ-037 Stimulus: reset, then imem_addr_F=0x40 with BadInstr_D=1 -> EProc_F=1 and EVAddr_F=0xD8 in the same cycle; next cycle ERR=0x40, ESync=1, InHandler=1.
REQ-038 Stimulus: in IDLE, NextPC_F=0x104, ExtIRQ=1 -> ERR=0x104, ESync=2; then ExcAck=1 and ERet_D=1 -> EVAddr_F=0x104, EProc_F=1, InHandler=0 on the next cycle.
REQ-039 Stimulus: ExtIRQ pulse while in HANDLER with no ExcAck, then ERet_D -> IRQ taken on the very next cycle, EVAddr_F=0xD8.
REQ-040 Stimulus: BadInstr_D=1 and ExtIRQ=1 together in IDLE -> ESync=1 and ERR=imem_addr_F.
REQ-041 Stimulus: BadInstr_D=1 in HANDLER -> DoubleFault=1 and state FAULT, PC held; reset=1 -> all outputs return to 0 and state IDLE.
REQ-042 Stimulus: EXC_TIMER_EN defined, TIMER_PERIOD=8, no other activity -> first redirect at cycle 8 after reset with ESync=3; macro undefined -> no redirect within 100 cycles.
